// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state enum, default widths, JUMPR opcode and NOP word.
package fetch_pkg;

   localparam int DEF_PC_W = 8;
   localparam int DEF_IR_W = 16;

   localparam logic [7:0]  JUMPR_OPC = 8'b10011010;
   localparam logic [15:0] NOP       = 16'h0000;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_e;

endpackage

// File: rtl/jumpr_predecode.sv
// Combinational JUMPR recognizer and relative-target adder for fetch.
// Ports: pc, rom_data in; is_jumpr, target (pc + 1 + sext(imm8)) out.
module jumpr_predecode
   import fetch_pkg::*;
#(
   parameter int PC_W = DEF_PC_W,
   parameter int IR_W = DEF_IR_W
) (
   input  logic [PC_W-1:0] pc,
   input  logic [IR_W-1:0] rom_data,
   output logic            is_jumpr,
   output logic [PC_W-1:0] target
);

   logic [PC_W-1:0] offset;

   assign is_jumpr = (rom_data[15:8] == JUMPR_OPC);
   assign offset   = PC_W'($signed(rom_data[7:0]));
   assign target   = pc + PC_W'(1) + offset;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, drives the ROM address and buffers one
// instruction toward decode over ir_valid/ir_ready. Applies execute
// redirects (highest priority) and halts on halt_req until redirected.
// Ports: clk, rst (async, active-high); rom_addr/rom_data to ROM;
// ir, ir_pc, ir_valid, ir_ready to decode; redirect_valid/redirect_pc,
// halt_req in; halted out.
// Build option: FETCH_JUMPR_PREDECODE_EN resolves JUMPR at fetch time.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int PC_W = DEF_PC_W,
   parameter int IR_W = DEF_IR_W
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] rom_addr,
   input  logic [IR_W-1:0] rom_data,
   output logic [IR_W-1:0] ir,
   output logic [PC_W-1:0] ir_pc,
   output logic            ir_valid,
   input  logic            ir_ready,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt_req,
   output logic            halted
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0] ir_pc_q, ir_pc_d;
   logic            ir_valid_q, ir_valid_d;
   logic [PC_W-1:0] next_pc;
   logic            slot_free;

`ifdef FETCH_JUMPR_PREDECODE_EN
   logic            is_jumpr;
   logic [PC_W-1:0] jumpr_tgt;

   jumpr_predecode #(
      .PC_W (PC_W),
      .IR_W (IR_W)
   ) u_predecode (
      .pc       (pc_q),
      .rom_data (rom_data),
      .is_jumpr (is_jumpr),
      .target   (jumpr_tgt)
   );

   assign next_pc = is_jumpr ? jumpr_tgt : pc_q + PC_W'(1);
`else
   assign next_pc = pc_q + PC_W'(1);
`endif

   assign slot_free = !ir_valid_q || ir_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = ir_valid_q;
      if (redirect_valid) begin
         // Buffered word is stale on a redirect, even if decode takes it.
         pc_d       = redirect_pc;
         ir_valid_d = 1'b0;
         state_d    = RUN;
      end else begin
         unique case (state_q)
            BOOT: begin
               state_d = RUN;
               if (ir_ready) ir_valid_d = 1'b0;
            end
            RUN: begin
               if (slot_free) begin
                  ir_d       = rom_data;
                  ir_pc_d    = pc_q;
                  ir_valid_d = 1'b1;
                  pc_d       = next_pc;
               end
               if (halt_req) state_d = HALT;
            end
            HALT: begin
               if (ir_ready) ir_valid_d = 1'b0;
            end
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= '0;
         ir_q       <= IR_W'(NOP);
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_pc_q    <= ir_pc_d;
         ir_valid_q <= ir_valid_d;
      end
   end

   assign rom_addr = pc_q;
   assign ir       = ir_q;
   assign ir_pc    = ir_pc_q;
   assign ir_valid = ir_valid_q;
   assign halted   = (state_q == HALT);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that drives the 8-bit address of the program ROM and buffers its 16-bit output toward the decode stage. It owns the program counter and presents one instruction at a time over a valid/ready handshake. It applies redirects from the execute stage and halts on request. Optionally, it resolves relative jumps (JUMPR) at fetch time without waiting for execute.

## Interface
- `PC_W`, 8: program counter / ROM address width
- `IR_W`, 16: instruction width
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: asynchronous, active-high reset
- `rom_addr` output PC_W: address to program ROM; equals internal pc register
- `rom_data` input IR_W: ROM word for `rom_addr`, combinational, valid same cycle
- `ir` output IR_W: buffered instruction
- `ir_pc` output PC_W: address `ir` was fetched from
- `ir_valid` output 1: `ir`/`ir_pc` hold an unconsumed instruction
- `ir_ready` input 1: decode accepts `ir` this cycle
- `redirect_valid` input 1: execute-stage redirect request
- `redirect_pc` input PC_W: redirect target
- `halt_req` input 1: stop fetching after current cycle
- `halted` output 1: state is HALT

## Operation
- States: BOOT, RUN, HALT.
- Reset values:
  - pc=0, ir=0, ir_pc=0, ir_valid=0, halted=0.
  - State is BOOT.
- BOOT → RUN unconditionally on the first clock after reset release. No capture occurs in BOOT.
- Buffer slot is free when `!ir_valid || ir_ready`.
- RUN, slot free, no redirect:
  - `ir<=rom_data`, `ir_pc<=pc`, `ir_valid<=1`.
  - `pc<=next_pc`.
- RUN, slot not free: pc, ir, ir_pc and ir_valid all hold (stall).
- `next_pc = pc+1` modulo 2^PC_W, so 255 → 0 wraps silently.
- Accepted without refill: if `ir_ready` is high and no capture occurs (HALT, BOOT, or redirect cycle), `ir_valid<=0`.
- Redirect has highest priority in every state:
  - `pc<=redirect_pc`, `ir_valid<=0`; the buffered instruction is discarded even if `ir_ready` is high.
  - No capture occurs in the redirect cycle.
  - State goes to RUN, even from HALT or BOOT.
- halt_req in RUN, no redirect:
  - The capture in that cycle still happens.
  - Then state goes to HALT and `halted=1`.
- HALT:
  - No captures; the buffered instruction drains normally.
  - The only exit is `redirect_valid`.
- Simultaneous halt_req and redirect_valid: redirect wins; halt_req is ignored.
- halt_req while in HALT has no effect.
- Reset mid-operation: all state returns to reset values immediately, and `rom_addr` goes to 0 asynchronously.

## Timing
- `rom_addr` is registered; it changes only on clock edges (or on reset).
- Fetch throughput: 1 instruction/cycle while `ir_ready` is held high.
- First `ir_valid` rises at the 2nd rising edge after reset deassertion, with `ir_pc=0`.
- Redirect latency: redirect sampled at edge N; the target instruction is valid after edge N+1.
- `ir` is stable while `ir_valid && !ir_ready`.
- No combinational path from `ir_ready` or `redirect_*` to `rom_addr`.

## Configuration
- `FETCH_JUMPR_PREDECODE_EN` defined:
  - JUMPR is matched when a captured word has `rom_data[15:8]==8'b10011010`.
  - For a JUMPR, `next_pc = pc + 1 + sext(rom_data[7:0])` modulo 2^PC_W instead of pc+1.
  - The JUMPR word is still presented on `ir` so decode can retire it as a NOP.
  - An external redirect in the same cycle overrides the predecoded target.
- Macro undefined: no predecode; `next_pc` is always pc+1, and execute must issue a redirect for JUMPR.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (BOOT, RUN, HALT),
  - `JUMPR_OPC` = 8'b10011010,
  - default widths PC_W / IR_W,
  - NOP = 16'h0000.
- One sub-module: `jumpr_predecode`.
  - Purely combinational; inputs `pc` and `rom_data`, outputs `is_jumpr` and `target`.
  - Instantiated only under `FETCH_JUMPR_PREDECODE_EN`.

## Test plan
- Reset, `ir_ready=1`, ROM words A0..A3 at 0..3 → `ir_pc` sequence 0,1,2,3 on consecutive cycles starting 2 edges after reset release; `ir` equals ROM word for each.
- Hold `ir_ready=0` for 3 cycles after `ir_pc=1` → `ir`, `ir_pc`, `rom_addr=2` frozen. Release → `ir_pc` 2 next cycle, no skipped or duplicated address.
- `redirect_valid=1`, `redirect_pc=8'h40` while `ir_valid=1` → `ir_valid=0` next cycle, then `ir_pc=8'h40`. Simultaneous halt_req is ignored (`halted=0`).
- Start at pc=8'hFF → `ir_pc` FF followed by 00.
- With macro: word 16'b1001101011111101 at address 2 → after `ir_pc=2`, next `ir_pc=0`. Without macro: next `ir_pc=3`.
- halt_req at `ir_pc=5`:
  - Address 6 is still captured, then `halted=1` and no further fetches for 10 cycles.
  - Then redirect to 8'h10 → `halted=0`, next `ir_pc=8'h10`.
  - Asserting `rst` mid-stream → `rom_addr=0` and `ir_valid=0` immediately.
